// File: rtl/rf_pkg.sv
// Shared types and helpers for the dual-write register file with dirty-register dump channel.
package rf_pkg;

  localparam int RF_WIDTH_DEF  = 8;
  localparam int RF_ADDR_W_DEF = 2;

  typedef enum logic {
    RF_IDLE = 1'b0,
    RF_SCAN = 1'b1
  } rf_state_e;

  typedef enum logic [1:0] {
    RF_SRC_ARRAY = 2'd0,
    RF_SRC_WP0   = 2'd1,
    RF_SRC_WP1   = 2'd2,
    RF_SRC_ZERO  = 2'd3
  } rf_src_e;

  // Hardwired zero beats any bypass; port 1 beats port 0.
  function automatic rf_src_e rf_read_src(input logic bypass, input logic zero_reg,
                                          input logic is_zero, input logic hit0,
                                          input logic hit1);
    if (zero_reg && is_zero) return RF_SRC_ZERO;
    if (bypass && hit1)      return RF_SRC_WP1;
    if (bypass && hit0)      return RF_SRC_WP0;
    return RF_SRC_ARRAY;
  endfunction

endpackage

// File: rtl/rf_dump_ctrl.sv
// Dump sweep controller: walks every address once, presenting a beat for each dirty register.
//
// state   | meaning
// RF_IDLE | no sweep; pointer parked at 0, waiting for dump_start
// RF_SCAN | sweep running; beat offered when dirty[ptr], else pointer steps on
module rf_dump_ctrl
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dump_start,
  input  logic                   dump_ready,
  input  logic [2**ADDR_W-1:0]   dirty,
  output logic                   dump_busy,
  output logic                   dump_valid,
  output logic                   dump_done,
  output logic [ADDR_W-1:0]      dump_addr,
  output logic                   dirty_clr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    valid   = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (dump_start) begin
          state_d = RF_SCAN;
          ptr_d   = '0;
        end
      end
      RF_SCAN: begin
        valid = dirty[ptr_q];
        // Clean entries cost one cycle each; dirty ones wait for the consumer.
        if (!valid || dump_ready) begin
          if (ptr_q == LAST) begin
            state_d = RF_IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  assign dump_busy  = (state_q == RF_SCAN);
  assign dump_valid = valid;
  assign dump_done  = done_q;
  assign dump_addr  = ptr_q;
  assign dirty_clr  = valid && dump_ready;

endmodule

// File: rtl/register_file_v2.sv
// Dual-write register file with combinational read/bypass muxes, dirty tracking
// and a valid/ready dump of dirty registers in address order.
module register_file_v2
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_DEF,
  parameter int ADDR_W   = RF_ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      waddr0,
  input  logic [WIDTH-1:0]       wdata0,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      waddr1,
  input  logic [WIDTH-1:0]       wdata1,
  input  logic [ADDR_W-1:0]      out1_sel,
  input  logic [ADDR_W-1:0]      out2_sel,
  output logic [WIDTH-1:0]       out1,
  output logic [WIDTH-1:0]       out2,
  output logic [2**ADDR_W-1:0]   dirty,
  input  logic                   dump_start,
  output logic                   dump_busy,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [ADDR_W-1:0]      dump_addr,
  output logic [WIDTH-1:0]       dump_data,
  output logic                   dump_done
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic             wr0, wr1;
  logic             dirty_clr;

  // Writes to a hardwired zero register are dropped entirely, including dirty marking.
  assign wr0 = en && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1 = en && we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  function automatic logic [WIDTH-1:0] read_mux(input logic [ADDR_W-1:0] sel);
    rf_src_e src;
    src = rf_read_src(BYPASS != 0, ZERO_REG != 0, sel == '0,
                      wr0 && (waddr0 == sel), wr1 && (waddr1 == sel));
    case (src)
      RF_SRC_ZERO: read_mux = '0;
      RF_SRC_WP1:  read_mux = wdata1;
      RF_SRC_WP0:  read_mux = wdata0;
      default:     read_mux = mem_q[sel];
    endcase
  endfunction

  rf_dump_ctrl #(.ADDR_W(ADDR_W)) u_dump_ctrl (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dirty      (dirty_q),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_addr  (dump_addr),
    .dirty_clr  (dirty_clr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dirty_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      dirty_q <= dirty_d;
    end
  end

  // Clear from an accepted beat is applied first so a same-cycle write keeps the entry dirty.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    dirty_d = dirty_q;
    if (dirty_clr) dirty_d[dump_addr] = 1'b0;
    if (wr0) begin
      mem_d[waddr0]   = wdata0;
      dirty_d[waddr0] = 1'b1;
    end
    if (wr1) begin
      mem_d[waddr1]   = wdata1;
      dirty_d[waddr1] = 1'b1;
    end
  end

  assign out1      = read_mux(out1_sel);
  assign out2      = read_mux(out2_sel);
  assign dump_data = read_mux(dump_addr);
  assign dirty     = dirty_q;

endmodule

// File: tb/tb_register_file_v2.sv
// Scoreboard bench: two instances (bypass/no-zero and no-bypass/zero-reg) share stimulus
// and are compared against a behavioural model of the register file and dump sweep.
module tb_register_file_v2;

  logic       clk = 1'b0;
  logic       reset, en, we0, we1, dump_start, dump_ready;
  logic [1:0] waddr0, waddr1, out1_sel, out2_sel;
  logic [7:0] wdata0, wdata1;

  logic [7:0] out1_w [2];
  logic [7:0] out2_w [2];
  logic [7:0] ddata_w [2];
  logic [3:0] dirty_w [2];
  logic [1:0] daddr_w [2];
  logic       busy_w [2];
  logic       valid_w [2];
  logic       done_w [2];

  always #5 clk = ~clk;

  register_file_v2 #(.WIDTH(8), .ADDR_W(2), .BYPASS(1), .ZERO_REG(0)) u_dut_a (
    .clk(clk), .reset(reset), .en(en),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .out1_sel(out1_sel), .out2_sel(out2_sel), .out1(out1_w[0]), .out2(out2_w[0]),
    .dirty(dirty_w[0]), .dump_start(dump_start), .dump_busy(busy_w[0]),
    .dump_valid(valid_w[0]), .dump_ready(dump_ready), .dump_addr(daddr_w[0]),
    .dump_data(ddata_w[0]), .dump_done(done_w[0])
  );

  register_file_v2 #(.WIDTH(8), .ADDR_W(2), .BYPASS(0), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .reset(reset), .en(en),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .out1_sel(out1_sel), .out2_sel(out2_sel), .out1(out1_w[1]), .out2(out2_w[1]),
    .dirty(dirty_w[1]), .dump_start(dump_start), .dump_busy(busy_w[1]),
    .dump_valid(valid_w[1]), .dump_ready(dump_ready), .dump_addr(daddr_w[1]),
    .dump_data(ddata_w[1]), .dump_done(done_w[1])
  );

  typedef struct {
    int inst;
    int out1;
    int out2;
    int dirty;
    int addr;
    int busy;
    int valid;
    int done;
  } exp_t;

  typedef struct {
    int inst;
    int addr;
    int data;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    checking = 1'b0;

  // Model state, instance 0 = bypass, instance 1 = hardwired zero without bypass.
  int m_mem [2][4];
  bit m_dirty [2][4];
  bit m_scan [2];
  int m_ptr [2];
  bit m_done [2];

  function automatic bit byp(int k); return k == 0; endfunction
  function automatic bit zr(int k);  return k == 1; endfunction

  function automatic bit eff(int k, int port);
    if (port == 0) return en && we0 && !(zr(k) && int'(waddr0) == 0);
    return en && we1 && !(zr(k) && int'(waddr1) == 0);
  endfunction

  function automatic int model_read(int k, int sel);
    if (zr(k) && sel == 0) return 0;
    if (byp(k) && eff(k, 1) && int'(waddr1) == sel) return int'(wdata1);
    if (byp(k) && eff(k, 0) && int'(waddr0) == sel) return int'(wdata0);
    return m_mem[k][sel];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_mem[k][i]   = 0;
        m_dirty[k][i] = 1'b0;
      end
      m_scan[k] = 1'b0;
      m_ptr[k]  = 0;
      m_done[k] = 1'b0;
    end
  endtask

  // Apply one cycle of inputs and post the expected observable state for this cycle.
  task automatic drive(input bit r, input bit e, input bit w0, input int a0, input int d0,
                       input bit w1, input int a1, input int d1, input int s1, input int s2,
                       input bit st, input bit rd);
    reset = r; en = e;
    we0 = w0; waddr0 = 2'(a0); wdata0 = 8'(d0);
    we1 = w1; waddr1 = 2'(a1); wdata1 = 8'(d1);
    out1_sel = 2'(s1); out2_sel = 2'(s2);
    dump_start = st; dump_ready = rd;
    checking = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_t x;
      int dv;
      dv = 0;
      for (int i = 0; i < 4; i++) if (m_dirty[k][i]) dv = dv | (1 << i);
      x.inst  = k;
      x.out1  = model_read(k, s1);
      x.out2  = model_read(k, s2);
      x.dirty = dv;
      x.addr  = m_ptr[k];
      x.busy  = int'(m_scan[k]);
      x.valid = int'(m_scan[k] && m_dirty[k][m_ptr[k]]);
      x.done  = int'(m_done[k]);
      exp_q.push_back(x);
      if (x.valid != 0 && rd) begin
        beat_t b;
        b.inst = k;
        b.addr = m_ptr[k];
        b.data = model_read(k, m_ptr[k]);
        beat_q.push_back(b);
      end
    end
  endtask

  task automatic idle(input int s1, input int s2, input bit st, input bit rd);
    drive(0, 1, 0, 0, 0, 0, 0, 0, s1, s2, st, rd);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit v;
        v = m_scan[k] && m_dirty[k][m_ptr[k]];
        m_done[k] = 1'b0;
        if (v && dump_ready) m_dirty[k][m_ptr[k]] = 1'b0;
        if (eff(k, 0)) begin
          m_mem[k][int'(waddr0)]   = int'(wdata0);
          m_dirty[k][int'(waddr0)] = 1'b1;
        end
        if (eff(k, 1)) begin
          m_mem[k][int'(waddr1)]   = int'(wdata1);
          m_dirty[k][int'(waddr1)] = 1'b1;
        end
        if (!m_scan[k]) begin
          if (dump_start) begin
            m_scan[k] = 1'b1;
            m_ptr[k]  = 0;
          end
        end else if (!v || dump_ready) begin
          if (m_ptr[k] == 3) begin
            m_scan[k] = 1'b0;
            m_ptr[k]  = 0;
            m_done[k] = 1'b1;
          end else begin
            m_ptr[k] = m_ptr[k] + 1;
          end
        end
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        if (exp_q.size() == 0) begin
          chk("exp_queue_empty", 32'(1), 32'(0));
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk($sformatf("inst%0d_out1", k),  32'(out1_w[k]),  32'(x.out1));
          chk($sformatf("inst%0d_out2", k),  32'(out2_w[k]),  32'(x.out2));
          chk($sformatf("inst%0d_dirty", k), 32'(dirty_w[k]), 32'(x.dirty));
          chk($sformatf("inst%0d_busy", k),  32'(busy_w[k]),  32'(x.busy));
          chk($sformatf("inst%0d_valid", k), 32'(valid_w[k]), 32'(x.valid));
          chk($sformatf("inst%0d_done", k),  32'(done_w[k]),  32'(x.done));
          chk($sformatf("inst%0d_daddr", k), 32'(daddr_w[k]), 32'(x.addr));
        end
        if (valid_w[k] === 1'b1 && dump_ready === 1'b1) begin
          if (beat_q.size() == 0) begin
            chk($sformatf("inst%0d_unexpected_beat", k), 32'(1), 32'(0));
          end else begin
            beat_t b;
            b = beat_q.pop_front();
            chk($sformatf("inst%0d_beat_inst", k), 32'(k), 32'(b.inst));
            chk($sformatf("inst%0d_beat_addr", k), 32'(daddr_w[k]), 32'(b.addr));
            chk($sformatf("inst%0d_beat_data", k), 32'(ddata_w[k]), 32'(b.data));
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    out1_sel = '0; out2_sel = '0; dump_start = 1'b0; dump_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then a single write becomes visible one cycle later.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    #2;
    chk("rst_busy", 32'(busy_w[0]), 32'(0));
    chk("rst_daddr", 32'(daddr_w[0]), 32'(0));
    step();
    drive(0, 1, 1, 2, 8'hA5, 0, 0, 0, 2, 1, 0, 0);
    step();
    idle(2, 1, 0, 0);
    #2;
    chk("rw_out1", 32'(out1_w[0]), 32'(8'hA5));
    chk("rw_dirty", 32'(dirty_w[0]), 32'(4'b0100));
    chk("rw_out2", 32'(out2_w[0]), 32'(0));
    step();

    // Same-address collision: port 1 wins, visible same cycle only with bypass.
    drive(0, 1, 1, 1, 8'h11, 1, 1, 8'h22, 0, 1, 0, 0);
    #2;
    chk("coll_bypass", 32'(out2_w[0]), 32'(8'h22));
    chk("coll_nobypass", 32'(out2_w[1]), 32'(0));
    step();
    idle(1, 1, 0, 0);
    #2;
    chk("coll_stored_a", 32'(out1_w[0]), 32'(8'h22));
    chk("coll_stored_b", 32'(out1_w[1]), 32'(8'h22));
    step();

    // Dump with two stall cycles on the first beat.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 1, 1, 8'h3C, 1, 3, 8'h7E, 0, 0, 0, 0); step();
    idle(0, 0, 1, 0); step();
    idle(0, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      idle(1, 3, 0, i == 2);
      #2;
      chk("bp_hold_valid", 32'(valid_w[0]), 32'(1));
      chk("bp_hold_addr", 32'(daddr_w[0]), 32'(1));
      chk("bp_hold_data", 32'(ddata_w[0]), 32'(8'h3C));
      step();
    end
    idle(0, 0, 0, 1); step();
    idle(0, 0, 0, 1);
    #2;
    chk("bp_beat2_data", 32'(ddata_w[1]), 32'(8'h7E));
    step();
    idle(0, 0, 0, 1);
    #2;
    chk("bp_done", 32'(done_w[0]), 32'(1));
    chk("bp_dirty", 32'(dirty_w[0]), 32'(0));
    step();
    idle(0, 0, 0, 1);
    #2;
    chk("bp_done_once", 32'(done_w[0]), 32'(0));
    step();

    // Write to the register whose beat is being accepted.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 1, 1, 8'h3C, 0, 0, 0, 0, 0, 0, 0); step();
    idle(0, 0, 1, 1); step();
    idle(0, 0, 0, 1); step();
    drive(0, 1, 0, 0, 0, 1, 1, 8'h99, 0, 0, 0, 1);
    #2;
    chk("wacc_data_bypass", 32'(ddata_w[0]), 32'(8'h99));
    chk("wacc_data_nobypass", 32'(ddata_w[1]), 32'(8'h3C));
    step();
    idle(1, 0, 0, 1);
    #2;
    chk("wacc_dirty_kept", 32'(dirty_w[0]), 32'(4'b0010));
    chk("wacc_stored", 32'(out1_w[1]), 32'(8'h99));
    step();
    repeat (2) begin idle(0, 0, 0, 1); step(); end

    // Hardwired zero register.
    drive(0, 1, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0); step();
    idle(0, 0, 0, 0);
    #2;
    chk("zr_read", 32'(out1_w[1]), 32'(0));
    chk("zr_dirty0", 32'(dirty_w[1][0]), 32'(0));
    chk("nozr_read", 32'(out1_w[0]), 32'(8'hFF));
    step();
    idle(0, 0, 1, 1); step();
    repeat (5) begin idle(0, 0, 0, 1); step(); end

    // Reset while a beat is being offered aborts the sweep silently.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 1, 1, 8'h55, 0, 0, 0, 0, 0, 0, 0); step();
    idle(0, 0, 1, 0); step();
    idle(0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("mid_valid_before", 32'(valid_w[0]), 32'(1));
    step();
    repeat (4) begin idle(1, 0, 0, 1); step(); end

    // Randomised traffic.
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      step();
    end

    checking = 1'b0;
    #10;
    chk("beats_left", 32'(beat_q.size()), 32'(0));
    chk("exp_left", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
